// File: rtl/aes_pkg.sv
// Shared AES-128 CBC front-end types: block/key widths, feeder FSM states and core latency.
package aes_pkg;

  localparam int AES_BLK_W    = 128;
  localparam int AES_KEY_W    = 128;
  localparam int AES_CORE_LAT = 12;

  typedef logic [AES_BLK_W-1:0] aes_blk_t;
  typedef logic [AES_KEY_W-1:0] aes_key_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_LOAD  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } cbc_state_e;

endpackage

// File: rtl/aes_ct_slot.sv
// Single-entry ciphertext holding register; capture sets valid, valid/ready handshake clears it.
// Data is held unchanged while ct_ready_i is low.
module aes_ct_slot
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap_en_i,
  input  logic [AES_BLK_W-1:0] cap_dat_i,
  input  logic                 cap_last_i,
  input  logic                 ct_ready_i,
  output logic                 ct_valid_o,
  output logic [AES_BLK_W-1:0] ct_data_o,
  output logic                 ct_last_o,
  output logic                 hs_o
);

  logic           vld_q, vld_d;
  aes_blk_t       dat_q, dat_d;
  logic           last_q, last_d;

  assign hs_o = vld_q & ct_ready_i;

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    last_d = last_q;
    if (cap_en_i) begin
      vld_d  = 1'b1;
      dat_d  = cap_dat_i;
      last_d = cap_last_i;
    end else if (hs_o) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      last_q <= last_d;
    end
  end

  assign ct_valid_o = vld_q;
  assign ct_data_o  = dat_q;
  assign ct_last_o  = last_q;

endmodule

// File: rtl/aes_cbc_feeder.sv
// CBC chaining front end for the AES-128 core: XOR with chain, one-cycle load, wait for done, emit.
// Optional core-done watchdog under AES_CBC_WDOG_EN; ct_ready low stalls plaintext intake.
module aes_cbc_feeder
  import aes_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 msg_start,
  input  logic [AES_KEY_W-1:0] key,
  input  logic [AES_BLK_W-1:0] iv,
  input  logic                 pt_valid,
  output logic                 pt_ready,
  input  logic [AES_BLK_W-1:0] pt_data,
  input  logic                 pt_last,
  output logic                 ct_valid,
  input  logic                 ct_ready,
  output logic [AES_BLK_W-1:0] ct_data,
  output logic                 ct_last,
  output logic                 core_ld,
  output logic [AES_KEY_W-1:0] core_key,
  output logic [AES_BLK_W-1:0] core_text_in,
  input  logic                 core_done,
  input  logic [AES_BLK_W-1:0] core_text_out,
  output logic                 busy,
  output logic                 err
);

  cbc_state_e state_q, state_d;
  aes_key_t   key_q, key_d;
  aes_blk_t   chain_q, chain_d;
  aes_blk_t   text_q, text_d;
  logic       last_q, last_d;

  logic       msg_accept;
  logic       cap_en;
  logic       ct_hs;
  logic       wdog_expire;

  assign msg_accept = (state_q == ST_IDLE) && msg_start;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    chain_d = chain_q;
    text_d  = text_q;
    last_d  = last_q;
    cap_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (msg_start) begin
          key_d   = key;
          chain_d = iv;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (pt_valid) begin
          text_d  = pt_data ^ chain_q;
          last_d  = pt_last;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_done) begin
          cap_en  = 1'b1;
          chain_d = core_text_out;
          state_d = ST_OUT;
        end else if (wdog_expire) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT: begin
        // Next plaintext only after this ciphertext leaves: it is the next chain value.
        if (ct_hs) state_d = last_q ? ST_IDLE : ST_ARMED;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      chain_q <= '0;
      text_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      text_q  <= text_d;
      last_q  <= last_d;
    end
  end

`ifdef AES_CBC_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;

  // Counter is zero on the first WAIT cycle, so expiry lands WDOG_CYCLES cycles after entry.
  assign wdog_expire = (state_q == ST_WAIT) && !core_done &&
                       (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = (state_q == ST_WAIT) ? wdog_q + 1'b1 : '0;
    err_d  = err_q;
    if (msg_accept)  err_d = 1'b0;
    if (wdog_expire) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdog_expire = 1'b0;
  assign err         = 1'b0;
`endif

  aes_ct_slot u_ct_slot (
    .clk        (clk),
    .rst        (rst),
    .cap_en_i   (cap_en),
    .cap_dat_i  (core_text_out),
    .cap_last_i (last_q),
    .ct_ready_i (ct_ready),
    .ct_valid_o (ct_valid),
    .ct_data_o  (ct_data),
    .ct_last_o  (ct_last),
    .hs_o       (ct_hs)
  );

  assign pt_ready     = (state_q == ST_ARMED);
  assign core_ld      = (state_q == ST_LOAD);
  assign busy         = (state_q != ST_IDLE);
  assign core_key     = key_q;
  assign core_text_in = text_q;

endmodule

// File: doc/aes_cbc_feeder.md
# aes_cbc_feeder

CBC-mode front end for the AES-128 encryption core. Accepts a stream of 128-bit plaintext blocks, XORs each with the chaining value (IV for the first block, previous ciphertext thereafter) and issues it to the core with a one-cycle load pulse. It then waits for the core's done pulse and presents the ciphertext on a valid/ready output. Sits directly upstream of the cipher core and owns its `ld`, `key` and `text_in` inputs.

## Interface
- `WDOG_CYCLES`, 20, core-done timeout in cycles counted in WAIT; used only with `AES_CBC_WDOG_EN`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `msg_start` in 1: starts a message; latches `key` and `iv`.
- `key` in 128: AES-128 key, sampled on an accepted `msg_start`.
- `iv` in 128: initialisation vector, sampled on an accepted `msg_start`.
- `pt_valid` in 1, `pt_ready` out 1, `pt_data` in 128, `pt_last` in 1: plaintext stream.
- `ct_valid` out 1, `ct_ready` in 1, `ct_data` out 128, `ct_last` out 1: ciphertext stream.
- `core_ld` out 1: load pulse to the core.
- `core_key` out 128: registered key, held for the whole message.
- `core_text_in` out 128: registered `pt_data ^ chain`.
- `core_done` in 1: core completion pulse.
- `core_text_out` in 128: core result, valid while `core_done` is high.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky watchdog flag; tied 0 without the macro.

## Operation
- States:
  - IDLE: `msg_start` latches key and iv into `core_key` and `chain`, clears `err`, then goes to ARMED.
  - ARMED: `pt_ready`=1. On `pt_valid&pt_ready`, register `core_text_in <= pt_data^chain` and `last_r <= pt_last`, then go to LOAD.
  - LOAD: `core_ld`=1 for exactly one cycle, then go to WAIT.
  - WAIT: on `core_done`, register `ct_data <= core_text_out` and `chain <= core_text_out`, copy `last_r` to `ct_last`, set `ct_valid`, then go to OUT.
  - OUT: `ct_valid` is held until `ct_ready`. On the handshake, clear `ct_valid`; go to IDLE if `last_r`, else ARMED.
- `pt_ready` is combinational from state: high only in ARMED.
- `msg_start` outside IDLE is ignored.
- `core_done` outside WAIT is ignored.
- A single-block message is legal: `pt_last`=1 on the first block.
- All XORs are full 128-bit, with no width conversion. Byte order is unchanged: bit 127 is the first byte.
- Reset value of every output is 0: `pt_ready`, `ct_valid`, `ct_data`, `ct_last`, `core_ld`, `core_key`, `core_text_in`, `busy`, `err`. Internal `chain`, `last_r` and the watchdog counter also reset to 0, and the FSM resets to IDLE.
- Reset mid-message (any state) returns to IDLE the following cycle. The in-flight block is discarded and `core_ld` is never re-pulsed.

## Timing
- Plaintext accepted at edge t; `core_text_in` is valid and `core_ld`=1 during cycle t+1.
- The core asserts `core_done` 12 cycles after sampling `core_ld`.
- `ct_valid` rises the cycle after `core_done` is sampled.
- Throughput with `ct_ready` held high: one block per 15 cycles, from ARMED accept to the next ARMED accept.
- `core_text_in` and `core_key` stay stable from LOAD until leaving WAIT.
- Back-pressure: `ct_ready`=0 holds the block in OUT indefinitely. No further plaintext is accepted, because the chain value depends on it.

## Configuration
- `AES_CBC_WDOG_EN` defined:
  - A counter clears on entry to WAIT and increments each cycle in WAIT.
  - If it reaches `WDOG_CYCLES` without `core_done`: set `err`, drop the block, go to IDLE, and assert no `ct_valid`.
  - `err` clears only on `rst` or an accepted `msg_start`.
- `AES_CBC_WDOG_EN` undefined: no counter; WAIT waits indefinitely; `err` is constant 0.

## Structure
- Shared package `aes_pkg`: `AES_BLK_W`=128, `AES_KEY_W`=128, FSM state encodings (IDLE, ARMED, LOAD, WAIT, OUT), and the core latency constant `AES_CORE_LAT`=12 for benches.
- One sub-module, `aes_ct_slot`: the ciphertext holding register, with `ct_valid`/`ct_ready` logic and capture enable.
- The cipher core itself is instantiated by the parent, not here.

## Test plan
- FIPS-197 vector: key 000102..0f, iv 0, single block `pt_data` 00112233445566778899aabbccddeeff with last=1 -> `ct_data` 69c4e0d86a7b0430d8cdb78070b4c55a, `ct_last`=1, return to IDLE, `busy`=0.
- Chaining: same key and iv=0, two blocks. Block 1 = 00112233..ff; block 2 = 69c4e0d8..5a ^ 00112233..ff. Both `core_text_in` values equal 00112233..ff, and both ciphertexts equal 69c4e0d8..5a.
- Back-pressure: hold `ct_ready`=0 for 30 cycles after the first `ct_valid`. Required: `pt_ready` stays 0, `ct_data` stays stable, and no second `core_ld`.
- Reset in WAIT: assert `rst` 5 cycles after `core_ld`. Required: all outputs 0 the next cycle, and a later `core_done` is ignored with no `ct_valid`.
- Ignored events: `msg_start` in ARMED does not change `core_key`. A spurious `core_done` in ARMED causes no `ct_valid`.
- With `AES_CBC_WDOG_EN`: suppress `core_done`. Required: `err`=1 exactly 20 cycles after WAIT entry, FSM returns to IDLE, and a new `msg_start` clears `err`.
